// File: rtl/dfx_stream_decoupler.sv
// Packet-safe DFX decoupler for one AXI-Stream master port driven by a reconfigurable module.
// Optional forced-drain timeout is compiled in with DFX_STREAM_DRAIN_TIMEOUT_EN.
module dfx_stream_decoupler #(
  parameter int DATA_WIDTH    = 32,
  parameter int CNT_WIDTH     = 16,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   S_AXI_TDATA,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_TKEEP,
  input  logic                    S_AXI_TVALID,
  input  logic                    S_AXI_TLAST,
  output logic                    S_AXI_TREADY,
  output logic [DATA_WIDTH-1:0]   M_AXI_TDATA,
  output logic [DATA_WIDTH/8-1:0] M_AXI_TKEEP,
  output logic                    M_AXI_TVALID,
  output logic                    M_AXI_TLAST,
  input  logic                    M_AXI_TREADY,
  input  logic                    decouple_req,
  output logic                    decouple_ack,
  output logic                    drain_timeout,
  output logic [CNT_WIDTH-1:0]    beat_cnt,
  output logic [CNT_WIDTH-1:0]    pkt_cnt
);

  typedef enum logic [1:0] {PASS, DRAIN, DECOUPLED} state_t;

  state_t state;
  logic   in_pkt;
  logic   stall;
  logic   gate_open;
  logic   accept;
  logic   drain_done;
  logic   timeout_hit;

  // In DRAIN the gate stays open only to finish a packet or a presented beat.
  assign gate_open = (state == PASS) || ((state == DRAIN) && (in_pkt || stall));

  assign M_AXI_TDATA  = gate_open ? S_AXI_TDATA  : '0;
  assign M_AXI_TKEEP  = gate_open ? S_AXI_TKEEP  : '0;
  assign M_AXI_TVALID = gate_open & S_AXI_TVALID;
  assign M_AXI_TLAST  = gate_open & S_AXI_TLAST;
  assign S_AXI_TREADY = gate_open & M_AXI_TREADY;

  assign accept     = M_AXI_TVALID & M_AXI_TREADY;
  assign drain_done = !gate_open || (accept && S_AXI_TLAST);

`ifdef DFX_STREAM_DRAIN_TIMEOUT_EN
  localparam int TW = $clog2(DRAIN_TIMEOUT + 1);

  logic [TW-1:0] to_cnt;
  logic          to_flag;

  assign timeout_hit   = (state == DRAIN) && !drain_done && (to_cnt == TW'(DRAIN_TIMEOUT - 1));
  assign drain_timeout = to_flag;

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt  <= '0;
      to_flag <= 1'b0;
    end else if ((state == PASS) && decouple_req) begin
      to_cnt  <= '0;
      to_flag <= 1'b0;
    end else if (state == DRAIN) begin
      to_cnt <= to_cnt + TW'(1);
      if (timeout_hit) to_flag <= 1'b1;
    end
  end
`else
  assign timeout_hit   = 1'b0;
  assign drain_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= PASS;
      decouple_ack <= 1'b0;
      in_pkt       <= 1'b0;
      stall        <= 1'b0;
      beat_cnt     <= '0;
      pkt_cnt      <= '0;
    end else begin
      if (accept) begin
        beat_cnt <= beat_cnt + CNT_WIDTH'(1);
        if (S_AXI_TLAST) pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
      end
      case (state)
        PASS: begin
          stall <= M_AXI_TVALID & ~M_AXI_TREADY;
          if (accept) in_pkt <= ~S_AXI_TLAST;
          if (decouple_req) state <= DRAIN;
        end
        DRAIN: begin
          stall <= M_AXI_TVALID & ~M_AXI_TREADY;
          if (accept) in_pkt <= ~S_AXI_TLAST;
          // A dropped request does not abort the drain; release happens from DECOUPLED.
          if (drain_done || timeout_hit) begin
            state        <= DECOUPLED;
            decouple_ack <= 1'b1;
          end
        end
        DECOUPLED: begin
          in_pkt <= 1'b0;
          stall  <= 1'b0;
          if (!decouple_req) begin
            state        <= PASS;
            decouple_ack <= 1'b0;
          end
        end
        default: begin
          state        <= PASS;
          decouple_ack <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dfx_stream_decoupler.sv
// Directed bench for dfx_stream_decoupler: packet-level reference model checked every cycle
// plus hand-computed literal expectations for each scenario.
module tb_dfx_stream_decoupler;

`ifdef DFX_STREAM_DRAIN_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_tdata;
  logic [3:0]  s_tkeep;
  logic        s_tvalid, s_tlast, s_tready;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tvalid, m_tlast, m_tready;
  logic        req, ack, dto;
  logic [15:0] beats, pkts;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  dfx_stream_decoupler #(.DATA_WIDTH(32), .CNT_WIDTH(16), .DRAIN_TIMEOUT(TO)) dut (
    .clk(clk), .reset(rst),
    .S_AXI_TDATA(s_tdata), .S_AXI_TKEEP(s_tkeep), .S_AXI_TVALID(s_tvalid),
    .S_AXI_TLAST(s_tlast), .S_AXI_TREADY(s_tready),
    .M_AXI_TDATA(m_tdata), .M_AXI_TKEEP(m_tkeep), .M_AXI_TVALID(m_tvalid),
    .M_AXI_TLAST(m_tlast), .M_AXI_TREADY(m_tready),
    .decouple_req(req), .decouple_ack(ack), .drain_timeout(dto),
    .beat_cnt(beats), .pkt_cnt(pkts)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 = forwarding, 1 = draining, 2 = isolated.
  int          m_mode = 0;
  bit          m_open, m_pend, m_flag, m_valid;
  int          m_dcyc;
  logic [15:0] m_beats, m_pkts;
  bit          g, acc, fin;

  function automatic bit m_gate();
    return (m_mode == 0) || (m_mode == 1 && (m_open || m_pend));
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      cyc <= 0;
      m_mode = 0; m_open = 0; m_pend = 0; m_flag = 0; m_dcyc = 0;
      m_beats = 0; m_pkts = 0; m_valid = 1;
    end else begin
      cyc <= cyc + 1;
      g   = m_gate();
      acc = g && s_tvalid && m_tready;
      fin = !g || (acc && s_tlast);
      if (acc) begin
        m_beats++;
        if (s_tlast) m_pkts++;
      end
      if (m_mode == 2) begin
        m_open = 0; m_pend = 0;
        if (!req) m_mode = 0;
      end else begin
        m_pend = g && s_tvalid && !m_tready;
        if (acc) m_open = !s_tlast;
        if (m_mode == 0) begin
          if (req) begin m_mode = 1; m_dcyc = 0; m_flag = 0; end
        end else begin
          m_dcyc++;
          if (fin) m_mode = 2;
          else if (TO_EN && m_dcyc == TO) begin m_mode = 2; m_flag = 1; end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      g = m_gate();
      chk("m_tvalid", 64'(m_tvalid), 64'(g & s_tvalid));
      chk("m_tdata",  64'(m_tdata),  g ? 64'(s_tdata) : 64'd0);
      chk("m_tkeep",  64'(m_tkeep),  g ? 64'(s_tkeep) : 64'd0);
      chk("m_tlast",  64'(m_tlast),  64'(g & s_tlast));
      chk("s_tready", 64'(s_tready), 64'(g & m_tready));
      chk("ack",      64'(ack),      64'(m_mode == 2));
      chk("beat_cnt", 64'(beats),    64'(m_beats));
      chk("pkt_cnt",  64'(pkts),     64'(m_pkts));
      chk("drain_to", 64'(dto),      64'(m_flag));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] d, input logic last, input logic v, input logic rdy);
    s_tdata = d; s_tkeep = 4'hF; s_tlast = last; s_tvalid = v; m_tready = rdy;
  endtask

  initial begin
    rst = 1; req = 0;
    drive(32'h0, 0, 0, 0);
    tick(); tick();
    rst = 0;
    s_tdata = 32'hA5A50001;
    @(negedge clk);
    chk("rst_ack", 64'(ack), 0);
    chk("rst_beats", 64'(beats), 0);
    chk("rst_pkts", 64'(pkts), 0);
    chk("rst_dto", 64'(dto), 0);
    chk("rst_fwd_data", 64'(m_tdata), 64'h A5A50001);

    // Idle port: request at cycle 10, ack at cycle 12.
    for (int i = 0; i < 50 && cyc != 10; i++) tick();
    req = 1;
    tick();
    drive(32'h11110000, 0, 1, 1);
    @(negedge clk);
    chk("idle_c11_ack", 64'(ack), 0);
    chk("idle_c11_noStart", 64'(m_tvalid), 0);
    tick();
    @(negedge clk);
    chk("idle_c12_ack", 64'(ack), 1);
    chk("idle_c12_tvalid", 64'(m_tvalid), 0);
    chk("idle_c12_tready", 64'(s_tready), 0);
    chk("idle_beats", 64'(beats), 0);
    req = 0; s_tvalid = 0;
    tick();
    @(negedge clk);
    chk("idle_release_ack", 64'(ack), 0);

    // Mid-packet request after beat 2.
    drive(32'hD1, 0, 1, 1); tick();
    drive(32'hD2, 0, 1, 1); tick();
    drive(32'hD3, 0, 1, 1); req = 1; tick();
    drive(32'hD4, 1, 1, 1);
    @(negedge clk);
    chk("mid_d4_data", 64'(m_tdata), 64'hD4);
    chk("mid_d4_last", 64'(m_tlast), 1);
    chk("mid_d4_ack", 64'(ack), 0);
    tick();
    s_tvalid = 0;
    @(negedge clk);
    chk("mid_ack", 64'(ack), 1);
    chk("mid_beats", 64'(beats), 4);
    chk("mid_pkts", 64'(pkts), 1);

    // Release, then a 2-beat packet passes with zero latency.
    req = 0; tick();
    drive(32'hE1, 0, 1, 1);
    @(negedge clk);
    chk("rel_ack", 64'(ack), 0);
    chk("rel_e1_data", 64'(m_tdata), 64'hE1);
    chk("rel_e1_valid", 64'(m_tvalid), 1);
    tick();
    drive(32'hE2, 1, 1, 1); tick();
    s_tvalid = 0;
    @(negedge clk);
    chk("rel_pkts", 64'(pkts), 2);
    chk("rel_beats", 64'(beats), 6);

    // Stalled beat when the request rises.
    drive(32'hF1, 0, 1, 0); req = 1; tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_hold_valid", 64'(m_tvalid), 1);
      chk("stall_hold_data", 64'(m_tdata), 64'hF1);
      chk("stall_hold_ack", 64'(ack), 0);
      if (i < 2) tick();
    end
    m_tready = 1; tick();
    drive(32'hF2, 1, 1, 1);
    @(negedge clk);
    chk("stall_f2_ack", 64'(ack), 0);
    tick();
    drive(32'hF3, 1, 1, 1);
    @(negedge clk);
    chk("stall_ack", 64'(ack), 1);
    chk("stall_iso_valid", 64'(m_tvalid), 0);
    chk("stall_beats", 64'(beats), 8);
    chk("stall_pkts", 64'(pkts), 3);
    req = 0; tick();
    @(negedge clk);
    chk("stall_rel_valid", 64'(m_tvalid), 1);
    tick();
    s_tvalid = 0;
    @(negedge clk);
    chk("stall_rel_beats", 64'(beats), 9);

    // Request drops mid-drain: drain completes, then releases.
    drive(32'h61, 0, 1, 1); req = 1; tick();
    s_tvalid = 0; req = 0; tick(); tick();
    @(negedge clk);
    chk("drop_ack_wait", 64'(ack), 0);
    drive(32'h62, 1, 1, 1); tick();
    s_tvalid = 0;
    @(negedge clk);
    chk("drop_ack", 64'(ack), 1);
    chk("drop_pkts", 64'(pkts), 5);
    tick();
    @(negedge clk);
    chk("drop_release", 64'(ack), 0);

    // Open packet with the RM idle: forced timeout, or indefinite wait.
    drive(32'h71, 0, 1, 1); req = 1; tick();
    s_tvalid = 0;
    repeat (7) tick();
    @(negedge clk);
    chk("to_before_ack", 64'(ack), 0);
    tick();
    @(negedge clk);
    if (TO_EN) begin
      chk("to_ack", 64'(ack), 1);
      chk("to_flag", 64'(dto), 1);
      req = 0; tick(); tick(); tick();
      @(negedge clk);
      chk("to_flag_sticky", 64'(dto), 1);
      chk("to_rel_ack", 64'(ack), 0);
    end else begin
      chk("nto_ack", 64'(ack), 0);
      chk("nto_flag", 64'(dto), 0);
      repeat (3) tick();
      drive(32'h72, 1, 1, 1); tick();
      s_tvalid = 0;
      @(negedge clk);
      chk("nto_ack_done", 64'(ack), 1);
      req = 0; tick();
    end

    // Reset in mid-drain.
    drive(32'h81, 0, 1, 1); req = 1; tick();
    s_tvalid = 0; tick();
    rst = 1; req = 0; tick();
    rst = 0;
    drive(32'h91, 1, 1, 1);
    @(negedge clk);
    chk("rst2_ack", 64'(ack), 0);
    chk("rst2_beats", 64'(beats), 0);
    chk("rst2_pkts", 64'(pkts), 0);
    chk("rst2_dto", 64'(dto), 0);
    chk("rst2_fwd", 64'(m_tdata), 64'h91);
    tick();
    s_tvalid = 0;
    @(negedge clk);
    chk("rst2_beat1", 64'(beats), 1);
    chk("rst2_pkt1", 64'(pkts), 1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
